mem_port_scheduler: RTL
=======================

Name: mem_port_scheduler

Overview:
Shares the single memory-controller port between three block-level requesters: instruction cache (req 0), data cache (req 1) and page-table walker (req 2). It serialises one 512-bit block transaction at a time and forwards the address, write enable and write block of the selected requester. It returns the read block and a one-cycle completion pulse to the winner only. It sits between the caches/PTW and memory_controller, and adds a watchdog that aborts hung transactions.

Parameters:
ADDR_W, 64, address width
BLOCK_W, 512, cache-block width
TIMEOUT, 1023, max cycles in WAIT before abort (10-bit watchdog counter)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req  in  3  per-requester request, held high until its done pulse
addr0/addr1/addr2  in  ADDR_W each  block address per requester
wr_en  in  3  per-requester write (1) / read (0)
wdata1  in  BLOCK_W  dcache write block (only req 1 may write; wr_en[0], wr_en[2] ignored)
rdata  out  BLOCK_W  read block, valid with done
done  out  3  one-hot completion pulse
err  out  1  pulses with done when a transaction timed out
busy  out  1  high in any state other than IDLE
mem_req  out  1  start request to memory_controller
mem_addr  out  ADDR_W  address to memory_controller
mem_wr_en  out  1  write enable to memory_controller
mem_wdata  out  BLOCK_W  write block to memory_controller
mem_rdata  in  BLOCK_W  memory_controller data_out
mem_valid  in  1  memory_controller data_valid

Behaviour:
- Reset (rst low, async): state IDLE, done=0, err=0, busy=0, mem_req=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, rdata=0, rr_ptr=0, watchdog=0. Reset mid-transaction drops mem_req immediately. No done pulse is issued for the killed transaction.
- States: IDLE, WAIT, DONE.
- IDLE: if any req bit is set, pick a winner.
  - req[2] has fixed highest priority.
  - Otherwise round-robin between req[0] and req[1]. rr_ptr names the preferred one. After a grant to 0 or 1, rr_ptr points to the other.
  - On the selection edge, register the winner's address, wr_en and wdata into mem_* and set mem_req=1. Go to WAIT.
  - Latency: req sampled at edge N gives mem_req high after edge N.
- WAIT:
  - mem_req and mem_* are held stable. The watchdog increments each cycle.
  - On mem_valid=1: capture mem_rdata into rdata (reads; writes leave rdata unchanged), pulse done[winner]=1, drop mem_req, go to DONE.
  - If watchdog reaches TIMEOUT before mem_valid: pulse done[winner] and err together, drop mem_req, go to DONE.
  - mem_valid and timeout in the same cycle: treat as a normal completion, err=0.
- DONE: one turnaround cycle. done/err return to 0, then go to IDLE and clear the watchdog. The winner must deassert req in the cycle done is seen, so it is not re-granted.
- Back-to-back: mem_valid at edge M gives done high after M. The next grant is sampled at M+2, so mem_req is low for at least 2 cycles between transactions.
- A requester dropping req during WAIT does not cancel the transaction; done still pulses. A new req during WAIT waits.
- mem_valid outside WAIT is ignored.
- done is always one-hot or zero. Writes return done with rdata unchanged.

Test Plan:
- Single read: req=3'b001, addr0=0x1000. mem_valid 5 cycles after mem_req with mem_rdata=512'hA5... → mem_addr=0x1000, mem_wr_en=0; done=3'b001 for exactly one cycle with rdata=A5...; busy low 2 cycles later.
- Round-robin: req=3'b011 held, both rearmed after each done → grants alternate 0,1,0,1 (rr_ptr starts at 0). mem_addr alternates addr0/addr1.
- PTW priority: req=3'b111 → PTW served first. With PTW held continuously it wins every arbitration, while 0/1 keep alternating once PTW drops.
- Dcache write: req[1]=1, wr_en=3'b010, wdata1=512'h1234 → mem_wr_en=1, mem_wdata=512'h1234; done[1] pulses; rdata unchanged from its prior value.
- Timeout: TIMEOUT=8, no mem_valid → done[winner] and err high in the same cycle, 8 cycles after WAIT entry; mem_req low after; a following request is served normally.
- Async reset: assert rst low mid-WAIT between clock edges → mem_req, busy, done drop without a clock edge. After release, req=3'b010 is granted with rr_ptr=0 semantics.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// Serialises block transactions from icache (0), dcache (1) and PTW (2) onto the
// single memory-controller port. A watchdog aborts transactions that hang in WAIT.
module mem_port_scheduler #(
    parameter int ADDR_W  = 64,
    parameter int BLOCK_W = 512,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         req,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [ADDR_W-1:0]  addr2,
    input  logic [2:0]         wr_en,
    input  logic [BLOCK_W-1:0] wdata1,
    output logic [BLOCK_W-1:0] rdata,
    output logic [2:0]         done,
    output logic               err,
    output logic               busy,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wr_en,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_valid
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

    state_t            state;
    logic              rr_ptr;
    logic [1:0]        winner;
    logic [9:0]        wdog;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] gnt_addr;

    // PTW always wins; icache/dcache alternate via rr_ptr when both ask.
    always_comb begin
        gnt = 2'd0;
        if (req[2])
            gnt = 2'd2;
        else if (req[1:0] == 2'b11)
            gnt = rr_ptr ? 2'd1 : 2'd0;
        else if (req[1])
            gnt = 2'd1;
    end

    always_comb begin
        case (gnt)
            2'd1:    gnt_addr = addr1;
            2'd2:    gnt_addr = addr2;
            default: gnt_addr = addr0;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            winner    <= 2'd0;
            wdog      <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    err  <= 1'b0;
                    if (|req) begin
                        winner    <= gnt;
                        mem_req   <= 1'b1;
                        mem_addr  <= gnt_addr;
                        // only the dcache may write; other wr_en bits are dropped here
                        mem_wr_en <= (gnt == 2'd1) && wr_en[gnt];
                        mem_wdata <= (gnt == 2'd1) ? wdata1 : '0;
                        if (gnt != 2'd2)
                            rr_ptr <= (gnt == 2'd0);
                        wdog      <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_valid) begin
                        if (!mem_wr_en)
                            rdata <= mem_rdata;
                        done    <= 3'b001 << winner;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (wdog == WDOG_LAST) begin
                        done    <= 3'b001 << winner;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        wdog    <= wdog + 10'd1;
                        state   <= DONE;
                    end else begin
                        wdog <= wdog + 10'd1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    err   <= 1'b0;
                    wdog  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
